// File: rtl/rns_error_decode.sv
// rns_error_decode
// Walks one N-coefficient polynomial held mod q in a source BRAM and
// centre-lifts each coefficient into a small signed value. Each result is
// written back as sign+magnitude (bit MAGW = sign, bits MAGW-1:0 = magnitude).
// Coefficients that are out of range or too large for the magnitude field
// are counted as overflow.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   start          one-cycle pass request; ignored unless idle
//   q              odd modulus, latched when start is accepted
//   busy, done     pass in progress / one-cycle completion pulse
//   src_rd_addr    source BRAM read address
//   src_rd_data    source coefficient, BRAM_RD_LAT cycles after its address
//   dst_wr_addr    destination BRAM write address
//   dst_wr_data    sign+magnitude result
//   dst_wea        destination write enable
//   overflow       sticky: any coefficient saturated or invalid this pass
//   overflow_cnt   saturating count of such coefficients this pass
//
// state   | meaning
// S_IDLE  | waiting for start
// S_ISSUE | issuing read addresses 0..N-1, one per cycle
// S_DRAIN | waiting for the read/convert pipeline to empty
// S_DONE  | one-cycle done pulse
module rns_error_decode #(
    parameter int N           = 8192,
    parameter int LOGN        = 13,
    parameter int LOGQ        = 54,
    parameter int MAGW        = 5,
    parameter int BRAM_RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LOGQ-1:0]   q,
    output logic              busy,
    output logic              done,
    output logic [LOGN-1:0]   src_rd_addr,
    input  logic [LOGQ-1:0]   src_rd_data,
    output logic [LOGN-1:0]   dst_wr_addr,
    output logic [MAGW:0]     dst_wr_data,
    output logic              dst_wea,
    output logic              overflow,
    output logic [LOGN:0]     overflow_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [LOGQ-1:0] MAG_MAX   = LOGQ'(2**MAGW - 1);
    localparam logic [LOGN-1:0] LAST_ADDR = LOGN'(N - 1);

    state_t            state, state_nxt;
    logic [LOGN-1:0]   cnt;
    logic [LOGQ-1:0]   q_reg;
    logic              issue;
    logic              accept;

    // Valid/address delay line matching the BRAM read latency; the output
    // register below forms the final stage.
    logic [BRAM_RD_LAT-1:0] vld_sr;
    logic [LOGN-1:0]        addr_sr [BRAM_RD_LAT];

    logic [LOGQ-1:0]   half;
    logic [LOGQ-1:0]   mag_full;
    logic              neg;
    logic              invalid;
    logic              ovf_evt;
    logic [MAGW:0]     conv_data;

    assign issue       = (state == S_ISSUE);
    assign accept      = (state == S_IDLE) && start;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign src_rd_addr = issue ? cnt : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (cnt == LAST_ADDR) state_nxt = S_DRAIN;
            // Last write is the one with nothing still behind it in the pipe.
            S_DRAIN: if (dst_wea && !(|vld_sr)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            q_reg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) q_reg <= q;
            if (issue && cnt != LAST_ADDR) cnt <= cnt + 1'b1;
            else                           cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int k = 0; k < BRAM_RD_LAT; k++) addr_sr[k] <= '0;
        end else begin
            vld_sr[0]  <= issue;
            addr_sr[0] <= cnt;
            for (int k = 1; k < BRAM_RD_LAT; k++) begin
                vld_sr[k]  <= vld_sr[k-1];
                addr_sr[k] <= addr_sr[k-1];
            end
        end
    end

    // Centre lift: values above q/2 represent negatives q-c. A lifted zero is
    // only reachable from c=0, so it always comes out with sign 0.
    assign half = q_reg >> 1;

    always_comb begin
        mag_full = '0;
        neg      = 1'b0;
        invalid  = (src_rd_data >= q_reg);
        if (!invalid) begin
            if (src_rd_data <= half) begin
                mag_full = src_rd_data;
            end else begin
                mag_full = q_reg - src_rd_data;
                neg      = 1'b1;
            end
        end
        ovf_evt = invalid || (mag_full > MAG_MAX);
        if (invalid)           conv_data = {1'b0, {MAGW{1'b1}}};
        else if (ovf_evt)      conv_data = {neg, {MAGW{1'b1}}};
        else                   conv_data = {neg, mag_full[MAGW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_wea      <= 1'b0;
            dst_wr_addr  <= '0;
            dst_wr_data  <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            dst_wea <= vld_sr[BRAM_RD_LAT-1];
            if (vld_sr[BRAM_RD_LAT-1]) begin
                dst_wr_addr <= addr_sr[BRAM_RD_LAT-1];
                dst_wr_data <= conv_data;
            end
            if (accept) begin
                overflow     <= 1'b0;
                overflow_cnt <= '0;
            end else if (vld_sr[BRAM_RD_LAT-1] && ovf_evt) begin
                overflow <= 1'b1;
                if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rns_error_decode.sv
module tb_rns_error_decode;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int LOGQ = 54;
    localparam int MAGW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LOGQ-1:0]   q_in;
    logic              busy;
    logic              done;
    logic [LOGN-1:0]   src_rd_addr;
    logic [LOGQ-1:0]   src_rd_data;
    logic [LOGN-1:0]   dst_wr_addr;
    logic [MAGW:0]     dst_wr_data;
    logic              dst_wea;
    logic              overflow;
    logic [LOGN:0]     overflow_cnt;

    int passed = 0;
    int total  = 0;

    logic [LOGQ-1:0] src_mem [N];
    logic [MAGW:0]   dst_mem [N];
    logic [LOGQ-1:0] rd_d1, rd_d2;
    int              wr_total = 0;

    always #5 clk = ~clk;

    rns_error_decode #(.N(N), .LOGN(LOGN), .LOGQ(LOGQ), .MAGW(MAGW), .BRAM_RD_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .q            (q_in),
        .busy         (busy),
        .done         (done),
        .src_rd_addr  (src_rd_addr),
        .src_rd_data  (src_rd_data),
        .dst_wr_addr  (dst_wr_addr),
        .dst_wr_data  (dst_wr_data),
        .dst_wea      (dst_wea),
        .overflow     (overflow),
        .overflow_cnt (overflow_cnt)
    );

    // Two-cycle read latency source BRAM and write-capturing destination BRAM.
    always @(posedge clk) begin
        rd_d1 <= src_mem[src_rd_addr];
        rd_d2 <= rd_d1;
        if (dst_wea) begin
            dst_mem[dst_wr_addr] <= dst_wr_data;
            wr_total <= wr_total + 1;
        end
    end
    assign src_rd_data = rd_d2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src_mem[i] = '0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_pass(input logic [LOGQ-1:0] qv);
        @(negedge clk);
        q_in  = qv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        int w0;
        bit bad;
        rst   = 1'b1;
        start = 1'b0;
        q_in  = '0;
        clear_src();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wea", 64'(dst_wea), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ovf_cnt", 64'(overflow_cnt), 64'd0);
        check("rst_src_addr", 64'(src_rd_addr), 64'd0);
        check("rst_dst_addr", 64'(dst_wr_addr), 64'd0);
        check("rst_dst_data", 64'(dst_wr_data), 64'd0);
        rst = 1'b0;

        // Round trip, q=12289
        clear_src();
        src_mem[0] = 0; src_mem[1] = 5; src_mem[2] = 12288; src_mem[3] = 12258; src_mem[4] = 31;
        w0 = wr_total;
        run_pass(54'd12289);
        check("rt_d0", 64'(dst_mem[0]), 64'h00);
        check("rt_d1", 64'(dst_mem[1]), 64'h05);
        check("rt_d2", 64'(dst_mem[2]), 64'h21);
        check("rt_d3", 64'(dst_mem[3]), 64'h3F);
        check("rt_d4", 64'(dst_mem[4]), 64'h1F);
        check("rt_d5", 64'(dst_mem[5]), 64'h00);
        check("rt_ovf", 64'(overflow), 64'd0);
        check("rt_ovf_cnt", 64'(overflow_cnt), 64'd0);
        check("rt_writes", 64'(wr_total - w0), 64'd8);

        // Saturation
        clear_src();
        src_mem[0] = 12257; src_mem[1] = 6144; src_mem[2] = 32;
        run_pass(54'd12289);
        check("sat_d0", 64'(dst_mem[0]), 64'h3F);
        check("sat_d1", 64'(dst_mem[1]), 64'h1F);
        check("sat_d2", 64'(dst_mem[2]), 64'h1F);
        check("sat_ovf", 64'(overflow), 64'd1);
        check("sat_ovf_cnt", 64'(overflow_cnt), 64'd3);

        // Invalid inputs
        clear_src();
        src_mem[0] = 12289; src_mem[1] = '1;
        run_pass(54'd12289);
        check("inv_d0", 64'(dst_mem[0]), 64'h1F);
        check("inv_d1", 64'(dst_mem[1]), 64'h1F);
        check("inv_ovf", 64'(overflow), 64'd1);
        check("inv_ovf_cnt", 64'(overflow_cnt), 64'd2);

        // Half boundary at q=12289 (both sides saturate)
        clear_src();
        src_mem[0] = 6144; src_mem[1] = 6145;
        run_pass(54'd12289);
        check("half_pos", 64'(dst_mem[0]), 64'h1F);
        check("half_neg", 64'(dst_mem[1]), 64'h3F);
        check("half_ovf_cnt", 64'(overflow_cnt), 64'd2);

        // Half boundary without saturation, q=63 (half=31)
        clear_src();
        src_mem[0] = 31; src_mem[1] = 32; src_mem[2] = 62; src_mem[3] = 1;
        run_pass(54'd63);
        check("q63_d0", 64'(dst_mem[0]), 64'h1F);
        check("q63_d1", 64'(dst_mem[1]), 64'h3F);
        check("q63_d2", 64'(dst_mem[2]), 64'h21);
        check("q63_d3", 64'(dst_mem[3]), 64'h01);
        check("q63_ovf", 64'(overflow), 64'd0);

        // Cycle-accurate timing, with an ignored start (q=5) in cycle 5
        for (int i = 0; i < N; i++) src_mem[i] = LOGQ'(i);
        @(negedge clk);
        q_in  = 54'd12289;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check($sformatf("t_busy_c%0d", c), 64'(busy), 64'((c >= 1 && c <= 12) ? 1 : 0));
            check($sformatf("t_done_c%0d", c), 64'(done), 64'((c == 12) ? 1 : 0));
            check($sformatf("t_wea_c%0d", c), 64'(dst_wea), 64'((c >= 4 && c <= 11) ? 1 : 0));
            if (c <= 8)
                check($sformatf("t_src_addr_c%0d", c), 64'(src_rd_addr), 64'(c - 1));
            if (c >= 4 && c <= 11) begin
                check($sformatf("t_dst_addr_c%0d", c), 64'(dst_wr_addr), 64'(c - 4));
                check($sformatf("t_dst_data_c%0d", c), 64'(dst_wr_data), 64'(c - 4));
            end
            if (c == 5) begin
                start = 1'b1;
                q_in  = 54'd5;
            end
            if (c == 6) start = 1'b0;
        end

        // Reset in cycle 6 of a pass
        for (int i = 0; i < N; i++) src_mem[i] = 12257;
        @(negedge clk);
        q_in  = 54'd12289;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 5) check("mr_ovf_before", 64'(overflow), 64'd1);
            if (c == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("mr_wea_c7", 64'(dst_wea), 64'd0);
        check("mr_ovf_c7", 64'(overflow), 64'd0);
        check("mr_ovf_cnt_c7", 64'(overflow_cnt), 64'd0);
        check("mr_busy_c7", 64'(busy), 64'd0);
        bad = 0;
        for (int c = 8; c <= 14; c++) begin
            @(negedge clk);
            if (done || dst_wea || busy) bad = 1;
        end
        check("mr_quiet", 64'(bad), 64'd0);
        w0 = wr_total;
        run_pass(54'd12289);
        check("mr_fresh_writes", 64'(wr_total - w0), 64'd8);
        check("mr_fresh_ovf_cnt", 64'(overflow_cnt), 64'd8);

        // Back-to-back: start in DONE is ignored, next cycle is accepted
        clear_src();
        src_mem[0] = 12257; src_mem[1] = 6144; src_mem[2] = 32;
        run_pass(54'd12289);
        check("bb_prev_ovf", 64'(overflow), 64'd1);
        check("bb_prev_ovf_cnt", 64'(overflow_cnt), 64'd3);
        clear_src();
        src_mem[0] = 16;
        q_in  = 54'd17;
        start = 1'b1;
        @(negedge clk);
        check("bb_start_in_done_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("bb_busy", 64'(busy), 64'd1);
        check("bb_ovf_clr", 64'(overflow), 64'd0);
        check("bb_ovf_cnt_clr", 64'(overflow_cnt), 64'd0);
        wait_done();
        check("bb_d0", 64'(dst_mem[0]), 64'h21);
        check("bb_d1", 64'(dst_mem[1]), 64'h00);
        check("bb_ovf", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
